// File: rtl/key_event_queue_if.sv
// Producer/consumer bundle for key_event_queue: debouncer strobe in, consumer handshake out,
// plus loss statistics.
interface key_event_queue_if #(
  parameter int DEPTH = 8
);
  // Handshake: outByte is meaningful only while outValid=1. A transfer happens at every
  // posedge where outValid=1 and outReady=1. While outValid=1 and outReady=0, outByte holds.
  // keyByte is sampled only on a cycle where keyStrobe=1.
  logic [7:0]             keyByte;
  logic                   keyStrobe;
  logic [7:0]             outByte;
  logic                   outValid;
  logic                   outReady;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic [7:0]             dropCount;
  logic                   clearOverflow;

  modport master (
    output keyByte, keyStrobe, outReady, clearOverflow,
    input  outByte, outValid, count, overflow, dropCount
  );

  modport slave (
    input  keyByte, keyStrobe, outReady, clearOverflow,
    output outByte, outValid, count, overflow, dropCount
  );
endinterface

// File: rtl/key_event_queue.sv
// Circular FIFO between the keyboard debouncer strobe and a stallable consumer.
// Losses to a full queue are flagged (sticky) and counted with saturation.
module key_event_queue #(
  parameter int DEPTH     = 8,
  parameter int DROP_ZERO = 1
) (
  input logic              clk,
  input logic              RST,
  key_event_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic [7:0]    drop_q;

  logic accept;
  logic full;
  logic valid;
  logic pop;
  logic push;
  logic lose;

  always_comb begin
    accept = bus.keyStrobe && !((DROP_ZERO != 0) && (bus.keyByte == 8'h00));
    full   = (count_q == FULL_COUNT);
    valid  = (count_q != '0);
    pop    = valid && bus.outReady;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    push   = accept && (!full || pop);
    lose   = accept && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (!RST && push) begin
      mem[wr_ptr] <= bus.keyByte;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // A loss in the same cycle as a clear restarts the statistics at one event.
  always_ff @(posedge clk) begin
    if (RST) begin
      overflow_q <= 1'b0;
      drop_q     <= 8'h00;
    end else if (lose) begin
      overflow_q <= 1'b1;
      if (bus.clearOverflow) begin
        drop_q <= 8'h01;
      end else if (drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'h01;
      end
    end else if (bus.clearOverflow) begin
      overflow_q <= 1'b0;
      drop_q     <= 8'h00;
    end
  end

  assign bus.outValid  = valid;
  assign bus.outByte   = valid ? mem[rd_ptr] : 8'h00;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.dropCount = drop_q;
endmodule
